blit_cmd_queue: RTL and testbench

Producer side of the blitter command interface. Accepts 32-bit CPU register writes, stages three argument words, and on a write to the command register pushes one 104-bit command into a FIFO. Presents the FIFO head to the blitter command decoder as `p0_cmd`/`p0_cmd_valid` and retires it when the decoder asserts `cmd_next` in a non-stalled cycle. Sits between the CPU peripheral bus and the blitter pipeline.

---
 rtl/blit_pkg.sv | 41 ++++
 rtl/blit_fifo.sv | 62 ++++++
 rtl/blit_cmd_queue.sv | 117 +++++++++++
 tb/tb_blit_cmd_queue.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// Shared definitions for the blitter command path: command layout, CPU register map,
// opcode values and STATUS register bit positions.
package blit_pkg;

  localparam int CMD_W = 104;
  localparam int ARG_W = 32;
  localparam int OP_W  = 8;

  typedef enum logic [1:0] {
    REG_ARG0 = 2'd0,
    REG_ARG1 = 2'd1,
    REG_ARG2 = 2'd2,
    REG_CMD  = 2'd3
  } blit_reg_e;

  typedef enum logic [7:0] {
    OP_FILL   = 8'h01,
    OP_COPY   = 8'h02,
    OP_RECT   = 8'h03,
    OP_LINE   = 8'h04,
    OP_PIXEL  = 8'h05,
    OP_BLEND  = 8'h06,
    OP_SCALE  = 8'h07,
    OP_ROTATE = 8'h08,
    OP_CLIP   = 8'h09,
    OP_FLUSH  = 8'h0A
  } blit_op_e;

  localparam int STAT_OCC_W = 16;
  localparam int STAT_EMPTY = 16;
  localparam int STAT_FULL  = 17;
  localparam int STAT_OVF   = 31;

  function automatic logic [CMD_W-1:0] pack_cmd(input logic [OP_W-1:0] op,
                                                input logic [ARG_W-1:0] arg2,
                                                input logic [ARG_W-1:0] arg1,
                                                input logic [ARG_W-1:0] arg0);
    return {op, arg2, arg1, arg0};
  endfunction

endpackage

// File: rtl/blit_fifo.sv
// Show-ahead FIFO on a register array: the head entry is readable without a pop,
// and a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module blit_fifo #(
  parameter int WIDTH = 104,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  // Storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/blit_cmd_queue.sv
// CPU-facing blitter command queue: stages three argument words and pushes a command
// on each CMD write. Optional sticky overflow flag: define BLIT_CMD_OVERFLOW_EN.
module blit_cmd_queue
  import blit_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hw_write,
  input  logic             hw_read,
  input  logic [1:0]       hw_addr,
  input  logic [31:0]      hw_wdata,
  output logic [31:0]      hw_rdata,
  input  logic             stall,
  output logic [CMD_W-1:0] p0_cmd,
  output logic             p0_cmd_valid,
  input  logic             cmd_next,
  output logic             queue_full
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [ARG_W-1:0] arg_reg [3];
  logic [31:0]      hw_rdata_reg;
  logic [CMD_W-1:0] fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             cmd_write;
  logic             push_req;
  logic             pop;
  logic             overflow;
  logic [31:0]      status;

  assign cmd_write = hw_write && (hw_addr == REG_CMD);
  assign pop       = !fifo_empty && cmd_next && !stall;

`ifdef BLIT_CMD_OVERFLOW_EN
  logic         overflow_reg;
  logic [22:0]  unused_wdata;

  // Bit 31 on a CMD write is a clear-overflow request, not a command.
  assign push_req     = cmd_write && !hw_wdata[31];
  assign overflow     = overflow_reg;
  assign unused_wdata = hw_wdata[30:8];

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (cmd_write && hw_wdata[31]) begin
      overflow_reg <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      overflow_reg <= 1'b1;
    end
  end
`else
  logic [23:0]  unused_wdata;

  assign push_req     = cmd_write;
  assign overflow     = 1'b0;
  assign unused_wdata = hw_wdata[31:8];
`endif

  // Staging registers survive pushes so software only rewrites changed arguments.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        arg_reg[i] <= '0;
      end
    end else if (hw_write && (hw_addr != REG_CMD)) begin
      arg_reg[hw_addr] <= hw_wdata;
    end
  end

  blit_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_req),
    .push_data (pack_cmd(hw_wdata[OP_W-1:0], arg_reg[2], arg_reg[1], arg_reg[0])),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    status                   = '0;
    status[STAT_OCC_W-1:0]   = STAT_OCC_W'(fifo_count);
    status[STAT_EMPTY]       = fifo_empty;
    status[STAT_FULL]        = fifo_full;
    status[STAT_OVF]         = overflow;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hw_rdata_reg <= '0;
    end else if (hw_read) begin
      case (hw_addr)
        REG_ARG0: hw_rdata_reg <= arg_reg[0];
        REG_ARG1: hw_rdata_reg <= arg_reg[1];
        REG_ARG2: hw_rdata_reg <= arg_reg[2];
        default:  hw_rdata_reg <= status;
      endcase
    end
  end

  assign hw_rdata     = hw_rdata_reg;
  assign p0_cmd       = fifo_empty ? '0 : fifo_head;
  assign p0_cmd_valid = !fifo_empty;
  assign queue_full   = fifo_full;

endmodule

// File: tb/tb_blit_cmd_queue.sv
// Randomized and directed checks of blit_cmd_queue against a queue-based reference model.
// Build with or without BLIT_CMD_OVERFLOW_EN; the model follows the same setting.
module tb_blit_cmd_queue;

  localparam int DEPTH = 16;
`ifdef BLIT_CMD_OVERFLOW_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         hw_write;
  logic         hw_read;
  logic [1:0]   hw_addr;
  logic [31:0]  hw_wdata;
  logic [31:0]  hw_rdata;
  logic         stall;
  logic [103:0] p0_cmd;
  logic         p0_cmd_valid;
  logic         cmd_next;
  logic         queue_full;

  blit_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .hw_write     (hw_write),
    .hw_read      (hw_read),
    .hw_addr      (hw_addr),
    .hw_wdata     (hw_wdata),
    .hw_rdata     (hw_rdata),
    .stall        (stall),
    .p0_cmd       (p0_cmd),
    .p0_cmd_valid (p0_cmd_valid),
    .cmd_next     (cmd_next),
    .queue_full   (queue_full)
  );

  always #5 clock = ~clock;

  logic [103:0] mq [$];
  logic [31:0]  m_arg [3];
  bit           m_ovf;
  logic [31:0]  m_rdata;
  int           errors = 0;
  int           checks = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s        = 32'(mq.size());
    s[16]    = (mq.size() == 0);
    s[17]    = (mq.size() == DEPTH);
    s[31]    = m_ovf;
    return s;
  endfunction

  // Advance the model by the rules for the current inputs, clock the DUT, then compare.
  task automatic cycle();
    int           sz;
    bit           pop;
    bit           preq;
    logic [103:0] entry;
    sz    = mq.size();
    pop   = (sz > 0) && cmd_next && !stall;
    entry = {hw_wdata[7:0], m_arg[2], m_arg[1], m_arg[0]};
    if (reset) begin
      mq.delete();
      for (int i = 0; i < 3; i++) m_arg[i] = '0;
      m_ovf   = 1'b0;
      m_rdata = '0;
    end else begin
      if (hw_read) m_rdata = (hw_addr == 2'd3) ? m_status() : m_arg[hw_addr];
      preq = hw_write && (hw_addr == 2'd3) && !(OVF && hw_wdata[31]);
      if (OVF && hw_write && (hw_addr == 2'd3) && hw_wdata[31]) m_ovf = 1'b0;
      if (pop) void'(mq.pop_front());
      if (preq) begin
        if ((sz < DEPTH) || pop) mq.push_back(entry);
        else if (OVF) m_ovf = 1'b1;
      end
      if (hw_write && (hw_addr != 2'd3)) m_arg[hw_addr] = hw_wdata;
    end
    @(posedge clock);
    #1;
    hw_write = 1'b0;
    hw_read  = 1'b0;
    check("valid", 128'(p0_cmd_valid), 128'(mq.size() > 0));
    check("p0_cmd", 128'(p0_cmd), (mq.size() > 0) ? 128'(mq[0]) : 128'(0));
    check("queue_full", 128'(queue_full), 128'(mq.size() == DEPTH));
    check("hw_rdata", 128'(hw_rdata), 128'(m_rdata));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    hw_write = 1'b1;
    hw_addr  = a;
    hw_wdata = d;
    cycle();
  endtask

  task automatic rd(input logic [1:0] a);
    hw_read = 1'b1;
    hw_addr = a;
    cycle();
  endtask

  task automatic pop1();
    cmd_next = 1'b1;
    cycle();
    cmd_next = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    hw_write = 1'b0;
    hw_read  = 1'b0;
    hw_addr  = '0;
    hw_wdata = '0;
    stall    = 1'b0;
    cmd_next = 1'b0;
    cycle();
    reset = 1'b0;
    check("rst_valid", 128'(p0_cmd_valid), 128'(0));
    check("rst_rdata", 128'(hw_rdata), 128'(0));

    // Basic push then pop.
    wr(2'd0, 32'h0010_0020);
    wr(2'd1, 32'h0005_0004);
    wr(2'd2, 32'h0000_001F);
    wr(2'd3, 32'h0000_0003);
    check("t1_cmd", 128'(p0_cmd), 128'(104'h03_0000001F_00050004_00100020));
    pop1();
    check("t1_empty_valid", 128'(p0_cmd_valid), 128'(0));
    check("t1_empty_cmd", 128'(p0_cmd), 128'(0));

    // Fill to DEPTH+1; the last push is dropped.
    for (int i = 0; i <= DEPTH; i++) begin
      wr(2'd3, 32'(i + 1));
      if (i == DEPTH - 1) check("t2_full_at_16", 128'(queue_full), 128'(1));
    end
    rd(2'd3);
    check("t2_status", 128'(hw_rdata), OVF ? 128'(32'h8002_0010) : 128'(32'h0002_0010));
    if (OVF) begin
      wr(2'd3, 32'h8000_0000);
      rd(2'd3);
      check("t2_ovf_clear", 128'(hw_rdata), 128'(32'h0002_0010));
    end

    // Push in the same cycle as a pop while full.
    hw_write = 1'b1;
    hw_addr  = 2'd3;
    hw_wdata = 32'h0000_0020;
    cmd_next = 1'b1;
    cycle();
    cmd_next = 1'b0;
    rd(2'd3);
    check("t3_status", 128'(hw_rdata), 128'(32'h0002_0010));

    for (int i = 0; i < DEPTH; i++) begin
      check("t3_drain_op", 128'(p0_cmd[103:96]), (i < DEPTH - 1) ? 128'(i + 2) : 128'(8'h20));
      pop1();
    end
    check("t3_drained", 128'(p0_cmd_valid), 128'(0));

    // Stall holds the head even with cmd_next asserted.
    wr(2'd3, 32'h5);
    wr(2'd3, 32'h6);
    cmd_next = 1'b1;
    stall    = 1'b1;
    repeat (3) begin
      cycle();
      check("t4_stall_head", 128'(p0_cmd[103:96]), 128'(8'h05));
    end
    stall = 1'b0;
    cycle();
    cmd_next = 1'b0;
    check("t4_next_head", 128'(p0_cmd[103:96]), 128'(8'h06));
    pop1();

    // Staging registers persist across pushes.
    wr(2'd1, 32'h0000_1234);
    wr(2'd3, 32'h0A);
    wr(2'd3, 32'h09);
    check("t5_op_a", 128'(p0_cmd[103:96]), 128'(8'h0A));
    check("t5_arg1_a", 128'(p0_cmd[63:32]), 128'(32'h1234));
    pop1();
    check("t5_op_b", 128'(p0_cmd[103:96]), 128'(8'h09));
    check("t5_arg1_b", 128'(p0_cmd[63:32]), 128'(32'h1234));
    pop1();

    // Reset mid-operation.
    wr(2'd3, 32'h1);
    wr(2'd3, 32'h2);
    wr(2'd3, 32'h3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("t6_valid", 128'(p0_cmd_valid), 128'(0));
    rd(2'd3);
    check("t6_status", 128'(hw_rdata), 128'(32'h0001_0000));
    for (int i = 0; i < 3; i++) begin
      rd(2'(i));
      check("t6_arg", 128'(hw_rdata), 128'(0));
    end

    // Randomized traffic; early phase pops rarely so the queue fills.
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(299) == 0);
      hw_write = ($urandom_range(2) == 0);
      hw_read  = ($urandom_range(2) == 0);
      hw_addr  = ($urandom_range(1) == 0) ? 2'd3 : 2'($urandom_range(3));
      hw_wdata = $urandom;
      hw_wdata[31] = ($urandom_range(7) == 0);
      cmd_next = (n < 1500) ? ($urandom_range(3) == 0) : ($urandom_range(1) == 0);
      stall    = ($urandom_range(3) == 0);
      cycle();
    end
    reset    = 1'b0;
    cmd_next = 1'b0;
    stall    = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
